store_rmw_unit: RTL and testbench

//  MEM-stage store sizer for the word-only data memory. Performs SB/SH as a

---
 rtl/riscv_pkg.sv | 15 +
 rtl/store_lane_merge.sv | 27 ++
 rtl/store_rmw_unit.sv | 140 ++++++++++++++
 tb/tb_store_rmw_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the memory stage.
// Store sizes and store sequencer states.
package riscv_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/store_lane_merge.sv
// Byte/half lane merge of new store data into an old word.
// Purely combinational; non-store sizes pass the old word through.
module store_lane_merge
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] old_word,
  input  logic [15:0]           new_data,
  input  logic [2:0]            size,
  input  logic [1:0]            offset,
  output logic [DATA_WIDTH-1:0] merged
);

  // Overwrite only the addressed lane, keep the rest
  always_comb begin
    merged = old_word;
    unique case (1'b1)
      (size == F3_SB):
        merged[{offset, 3'b000} +: 8] = new_data[7:0];
      (size == F3_SH):
        merged[{offset[1], 4'b0000} +: 16] = new_data;
      default: ;
    endcase
  end

endmodule

// File: rtl/store_rmw_unit.sv
// MEM-stage store sizer for a word-only data memory.
// SW writes directly; SB/SH run read, merge, write.
module store_rmw_unit
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_write,
  input  logic                  mem_read,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic                  dmem_we,
  output logic                  dmem_re,
  output logic                  mem_write_bh,
  output logic                  store_misaligned
);

  state_t state_q;
  state_t state_d;

  logic                  is_sb;
  logic                  is_sh;
  logic                  is_sw;
  logic                  misal;
  logic                  sub_go;
  logic [ADDR_WIDTH-1:0] word_addr;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            off_q;
  logic [2:0]            f3_q;
  logic [15:0]           data_q;
  logic [DATA_WIDTH-1:0] merge_q;
  logic [DATA_WIDTH-1:0] merged;

  // Decode store size, alignment and sub-word start
  always_comb begin
    is_sb     = (funct3 == F3_SB);
    is_sh     = (funct3 == F3_SH);
    is_sw     = (funct3 == F3_SW);
    misal     = (is_sh & addr[0])
              | (is_sw & (addr[1:0] != 2'b00));
    sub_go    = mem_write
              & (is_sb | (is_sh & ~addr[0]));
    word_addr = {addr[ADDR_WIDTH-1:2], 2'b00};
  end

  store_lane_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_merge (
    .old_word (dmem_rdata),
    .new_data (data_q),
    .size     (f3_q),
    .offset   (off_q),
    .merged   (merged)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state: sub-word stores take READ then WRITE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (sub_go) state_d = ST_READ;
      ST_READ:  state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Capture sub-word store operands while EX/MEM is still live
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      off_q  <= '0;
      f3_q   <= '0;
      data_q <= '0;
    end else if (state_q == ST_IDLE && sub_go) begin
      addr_q <= word_addr;
      off_q  <= addr[1:0];
      f3_q   <= funct3;
      data_q <= wdata[15:0];
    end
  end

  // Register the merged word during READ
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    merge_q <= '0;
    else if (state_q == ST_READ) merge_q <= merged;
  end

  // Memory strobes, stall and trap outputs
  always_comb begin
    dmem_addr        = word_addr;
    dmem_wdata       = wdata;
    dmem_we          = 1'b0;
    dmem_re          = 1'b0;
    mem_write_bh     = 1'b0;
    store_misaligned = 1'b0;
    if (rst) begin
      unique case (state_q)
        ST_IDLE: begin
          if (mem_write) begin
            if (misal) begin
              store_misaligned = 1'b1;
            end else if (is_sw) begin
              dmem_we = 1'b1;
            end else if (sub_go) begin
              dmem_re      = 1'b1;
              mem_write_bh = 1'b1;
            end
          end else if (mem_read) begin
            dmem_re = 1'b1;
          end
        end
        ST_READ: begin
          dmem_addr    = addr_q;
          mem_write_bh = 1'b1;
        end
        ST_WRITE: begin
          dmem_addr  = addr_q;
          dmem_wdata = merge_q;
          dmem_we    = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_store_rmw_unit.sv
// Directed bench for store_rmw_unit.
// Golden memory model plus per-cycle expected output queue.
module tb_store_rmw_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] dmem_rdata = '0;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_we;
  logic        dmem_re;
  logic        mem_write_bh;
  logic        store_misaligned;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    bit          we;
    bit          re;
    bit          bh;
    bit          mis;
    bit          chk_a;
    bit          chk_d;
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  exp_t q[$];

  logic [31:0] mem  [256];
  logic [31:0] gold [256];

  store_rmw_unit #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_write        (mem_write),
    .mem_read         (mem_read),
    .funct3           (funct3),
    .addr             (addr),
    .wdata            (wdata),
    .dmem_rdata       (dmem_rdata),
    .dmem_addr        (dmem_addr),
    .dmem_wdata       (dmem_wdata),
    .dmem_we          (dmem_we),
    .dmem_re          (dmem_re),
    .mem_write_bh     (mem_write_bh),
    .store_misaligned (store_misaligned)
  );

  always #5 clk = ~clk;

  // Word memory with one-cycle read latency
  always @(posedge clk) begin
    if (dmem_we) mem[dmem_addr[9:2]] <= dmem_wdata;
    if (dmem_re) dmem_rdata <= mem[dmem_addr[9:2]];
  end

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  function automatic exp_t zexp();
    exp_t e;
    e.we = 0; e.re = 0; e.bh = 0; e.mis = 0;
    e.chk_a = 0; e.chk_d = 0; e.a = '0; e.d = '0;
    return e;
  endfunction

  // Per-cycle comparison, one tick before the rising edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      cyc++;
      if (q.size() > 0) e = q.pop_front();
      else e = zexp();
      chk($sformatf("c%0d_we", cyc), 32'(dmem_we), 32'(e.we));
      chk($sformatf("c%0d_re", cyc), 32'(dmem_re), 32'(e.re));
      chk($sformatf("c%0d_bh", cyc), 32'(mem_write_bh), 32'(e.bh));
      chk($sformatf("c%0d_mis", cyc), 32'(store_misaligned), 32'(e.mis));
      if (e.chk_a) chk($sformatf("c%0d_addr", cyc), dmem_addr, e.a);
      if (e.chk_d) chk($sformatf("c%0d_wdata", cyc), dmem_wdata, e.d);
    end
  end

  task automatic idle_cyc();
    @(negedge clk);
    mem_write = 0;
    mem_read = 0;
    q.push_back(zexp());
  endtask

  task automatic garbage();
    mem_write = 1;
    mem_read = 0;
    funct3 = 3'b010;
    addr = $urandom & 32'h3FC;
    wdata = $urandom;
  endtask

  task automatic load(logic [31:0] a);
    exp_t e;
    @(negedge clk);
    mem_write = 0; mem_read = 1; funct3 = 3'b010;
    addr = a; wdata = 32'h0;
    e = zexp();
    e.re = 1; e.chk_a = 1; e.a = a & ~32'h3;
    q.push_back(e);
  endtask

  task automatic store(logic [2:0] f3, logic [31:0] a,
                       logic [31:0] d, bit rd);
    exp_t e;
    int n;
    int sh;
    int wi;
    logic [31:0] mask;
    logic [31:0] nw;
    @(negedge clk);
    mem_write = 1; mem_read = rd;
    funct3 = f3; addr = a; wdata = d;
    n = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : (f3 == 3'b010) ? 4 : 0;
    wi = int'(a[9:2]);
    e = zexp();
    if (n == 0) begin
      q.push_back(e);
    end else if ((a % n) != 0) begin
      e.mis = 1;
      q.push_back(e);
    end else if (n == 4) begin
      e.we = 1; e.chk_a = 1; e.a = a; e.chk_d = 1; e.d = d;
      q.push_back(e);
      gold[wi] = d;
    end else begin
      sh = int'(a % 4) * 8;
      mask = ((n == 1) ? 32'hFF : 32'hFFFF) << sh;
      nw = (gold[wi] & ~mask) | ((d << sh) & mask);
      e.re = 1; e.bh = 1; e.chk_a = 1; e.a = a & ~32'h3;
      q.push_back(e);
      @(negedge clk);
      garbage();
      e = zexp();
      e.bh = 1; e.chk_a = 1; e.a = a & ~32'h3;
      q.push_back(e);
      @(negedge clk);
      garbage();
      e = zexp();
      e.we = 1; e.chk_a = 1; e.a = a & ~32'h3;
      e.chk_d = 1; e.d = nw;
      q.push_back(e);
      gold[wi] = nw;
    end
  endtask

  initial begin
    exp_t e;
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      gold[i] = '0;
    end
    rst = 0;
    mem_write = 1; funct3 = 3'b010;
    addr = 32'h100; wdata = 32'h12345678;
    repeat (2) begin
      @(negedge clk);
      q.push_back(zexp());
    end
    @(negedge clk);
    rst = 1;
    mem_write = 0;
    q.push_back(zexp());

    store(3'b010, 32'h100, 32'hDEADBEEF, 0);
    idle_cyc();
    chk("sw_mem", mem[8'h40], 32'hDEADBEEF);

    store(3'b010, 32'h100, 32'h11223344, 0);
    store(3'b000, 32'h102, 32'h000000AA, 0);
    idle_cyc();
    idle_cyc();
    chk("sb_gold", gold[8'h40], 32'h11AA3344);
    chk("sb_mem", mem[8'h40], 32'h11AA3344);

    store(3'b010, 32'h104, 32'h11223344, 0);
    store(3'b001, 32'h106, 32'h0000BEEF, 0);
    idle_cyc();
    idle_cyc();
    chk("sh_gold", gold[8'h41], 32'hBEEF3344);
    chk("sh_mem", mem[8'h41], 32'hBEEF3344);

    store(3'b001, 32'h101, 32'h0000FFFF, 0);
    store(3'b010, 32'h102, 32'hFFFFFFFF, 0);
    store(3'b010, 32'h103, 32'hFFFFFFFF, 0);
    idle_cyc();
    chk("misal_mem", mem[8'h40], 32'h11AA3344);

    store(3'b000, 32'h103, 32'h00000055, 0);
    store(3'b000, 32'h100, 32'h00001234, 0);
    store(3'b000, 32'h101, 32'h000000C7, 0);
    idle_cyc();
    idle_cyc();
    chk("b2b_gold", gold[8'h40], 32'h55AAC734);
    chk("b2b_mem", mem[8'h40], 32'h55AAC734);

    store(3'b001, 32'h104, 32'h1234CAFE, 1);
    store(3'b010, 32'h10C, 32'h01020304, 1);
    idle_cyc();
    idle_cyc();
    chk("shrd_mem", mem[8'h41], 32'hBEEFCAFE);

    store(3'b011, 32'h108, 32'hAAAAAAAA, 0);
    store(3'b100, 32'h108, 32'hAAAAAAAA, 0);
    load(32'h10A);
    load(32'h104);
    store(3'b000, 32'h107, 32'h00000099, 0);
    idle_cyc();
    idle_cyc();
    chk("sb3_mem", mem[8'h41], 32'h99EFCAFE);
    chk("ill_mem", mem[8'h42], 32'h00000000);

    @(negedge clk);
    mem_write = 1; mem_read = 0; funct3 = 3'b000;
    addr = 32'h108; wdata = 32'h77;
    e = zexp();
    e.re = 1; e.bh = 1; e.chk_a = 1; e.a = 32'h108;
    q.push_back(e);
    @(negedge clk);
    rst = 0;
    garbage();
    q.push_back(zexp());
    @(negedge clk);
    rst = 1;
    mem_write = 0;
    q.push_back(zexp());
    idle_cyc();
    store(3'b010, 32'h10C, 32'h0BADF00D, 0);
    idle_cyc();
    idle_cyc();
    chk("rst_drop_mem", mem[8'h42], 32'h00000000);
    chk("rst_sw_mem", mem[8'h43], 32'h0BADF00D);

    for (int i = 0; i < 256; i++) begin
      if (mem[i] !== gold[i])
        chk($sformatf("sweep_%0d", i), mem[i], gold[i]);
      else
        total++;
    end

    repeat (3) idle_cyc();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
